// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - decode/issue sequencer in front of the 64-bit combinational ALU
//
// Accepts one decoded RV64I-subset instruction per handshake, maps it to a
// 4-bit ALU operation, registers the ALU operands, captures the ALU result
// one cycle later and offers result + branch decision downstream.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    instruction handshake (in_ready only in IDLE)
//   opcode, funct3,
//   funct7_b5            instruction encoding fields
//   rs1_val, rs2_val,
//   imm                  operand sources (imm already sign-extended)
//   alu_a, alu_b, alu_op registered ALU inputs
//   alu_result, alu_zero combinational ALU outputs
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   out_result           captured ALU result (0 for illegal encodings)
//   out_branch_taken     branch decision for BEQ/BNE, 0 otherwise
//   out_illegal          encoding was not supported
//   op_count             completed output handshakes, wraps

module alu_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_branch_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_CUST0  = 7'b0001011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  // Which branch condition, if any, the EXEC cycle must evaluate.
  typedef enum logic [1:0] {
    BR_NONE,
    BR_EQ,
    BR_NE
  } br_t;

  state_t            state_q, state_d;
  br_t               br_q, br_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic              out_taken_q, out_taken_d;
  logic              out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  // Decode results for the instruction currently presented at the input.
  logic              dec_legal;
  logic [3:0]        dec_op;
  logic              dec_use_imm;
  br_t               dec_br;

  logic              accept;
  logic              handshake_out;

  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = OP_ADD;
    dec_use_imm = 1'b0;
    dec_br      = BR_NONE;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_op    = funct7_b5 ? OP_SUB : OP_ADD;
          end
          3'b111: begin
            dec_legal = 1'b1;
            dec_op    = OP_AND;
          end
          3'b110: begin
            dec_legal = 1'b1;
            dec_op    = OP_OR;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_I: begin
        dec_use_imm = 1'b1;
        case (funct3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_op    = OP_ADD;
          end
          3'b111: begin
            dec_legal = 1'b1;
            dec_op    = OP_AND;
          end
          3'b110: begin
            dec_legal = 1'b1;
            dec_op    = OP_OR;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      // Address generation: funct fields carry width info the ALU ignores.
      OPC_LOAD, OPC_STORE: begin
        dec_legal   = 1'b1;
        dec_op      = OP_ADD;
        dec_use_imm = 1'b1;
      end
      // Compare by subtraction; alu_zero then means rs1 == rs2.
      OPC_BRANCH: begin
        dec_op = OP_SUB;
        case (funct3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_br    = BR_EQ;
          end
          3'b001: begin
            dec_legal = 1'b1;
            dec_br    = BR_NE;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_CUST0: begin
        dec_op    = OP_NOR;
        dec_legal = (funct3 == 3'b000);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept        = (state_q == ST_IDLE) && in_valid;
  assign handshake_out = (state_q == ST_DONE) && out_ready;

  always_comb begin
    state_d       = state_q;
    br_d          = br_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    out_result_d  = out_result_q;
    out_taken_d   = out_taken_q;
    out_illegal_d = out_illegal_q;
    op_count_d    = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            alu_a_d  = rs1_val;
            alu_b_d  = dec_use_imm ? imm : rs2_val;
            alu_op_d = dec_op;
            br_d     = dec_br;
            state_d  = ST_EXEC;
          end else begin
            // Illegal encodings skip the ALU and leave its inputs untouched.
            br_d          = BR_NONE;
            out_result_d  = '0;
            out_taken_d   = 1'b0;
            out_illegal_d = 1'b1;
            state_d       = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        out_result_d  = alu_result;
        out_taken_d   = ((br_q == BR_EQ) &&  alu_zero) ||
                        ((br_q == BR_NE) && !alu_zero);
        out_illegal_d = 1'b0;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        if (handshake_out) begin
          op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      br_q          <= BR_NONE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= OP_AND;
      out_result_q  <= '0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      br_q          <= br_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      out_result_q  <= out_result_d;
      out_taken_q   <= out_taken_d;
      out_illegal_q <= out_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  assign in_ready         = (state_q == ST_IDLE);
  assign out_valid        = (state_q == ST_DONE);
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_op           = alu_op_q;
  assign out_result       = out_result_q;
  assign out_branch_taken = out_taken_q;
  assign out_illegal      = out_illegal_q;
  assign op_count         = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl

module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [63:0] rs1_val, rs2_val, imm;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_branch_taken;
  logic        out_illegal;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_count;
  logic [3:0]  exp_alu_op;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_branch_taken(out_branch_taken),
    .out_illegal(out_illegal), .op_count(op_count)
  );

  // Combinational ALU the controller drives.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 64'h0;
    endcase
    alu_zero = (alu_result == 64'h0);
  end

  typedef struct {
    logic        legal;
    logic [3:0]  op;
    logic [63:0] res;
    logic        taken;
  } exp_t;

  // Instruction-level reference: what the instruction means, not how it is built.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                                 input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im);
    exp_t e;
    e.legal = 1'b0; e.op = 4'b0000; e.res = 64'h0; e.taken = 1'b0;
    if (op == 7'b0110011 && f3 == 3'b000) begin
      e.legal = 1'b1; e.op = b5 ? 4'b0110 : 4'b0010; e.res = b5 ? r1 - r2 : r1 + r2;
    end else if (op == 7'b0110011 && f3 == 3'b111) begin
      e.legal = 1'b1; e.op = 4'b0000; e.res = r1 & r2;
    end else if (op == 7'b0110011 && f3 == 3'b110) begin
      e.legal = 1'b1; e.op = 4'b0001; e.res = r1 | r2;
    end else if (op == 7'b0010011 && f3 == 3'b000) begin
      e.legal = 1'b1; e.op = 4'b0010; e.res = r1 + im;
    end else if (op == 7'b0010011 && f3 == 3'b111) begin
      e.legal = 1'b1; e.op = 4'b0000; e.res = r1 & im;
    end else if (op == 7'b0010011 && f3 == 3'b110) begin
      e.legal = 1'b1; e.op = 4'b0001; e.res = r1 | im;
    end else if (op == 7'b0000011 || op == 7'b0100011) begin
      e.legal = 1'b1; e.op = 4'b0010; e.res = r1 + im;
    end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      e.legal = 1'b1; e.op = 4'b0110; e.res = r1 - r2;
      e.taken = (f3 == 3'b000) ? (r1 == r2) : (r1 != r2);
    end else if (op == 7'b0001011 && f3 == 3'b000) begin
      e.legal = 1'b1; e.op = 4'b1100; e.res = ~(r1 | r2);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    opcode    = 7'($urandom);
    funct3    = 3'($urandom);
    funct7_b5 = 1'($urandom);
    rs1_val   = {$urandom, $urandom};
    rs2_val   = {$urandom, $urandom};
    imm       = {$urandom, $urandom};
  endtask

  // One full transaction; hold = cycles of out_ready=0 while the result waits.
  task automatic do_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic b5, input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] im, input int hold, input bit no_wait);
    exp_t e;
    e = model(op, f3, b5, r1, r2, im);
    if (!no_wait) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1; opcode = op; funct3 = f3; funct7_b5 = b5;
    rs1_val = r1; rs2_val = r2; imm = im; out_ready = 1'b0;
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    if (e.legal) begin
      exp_alu_op = e.op;
      check({tag, ".alu_op"}, 64'(alu_op), 64'(exp_alu_op));
      check({tag, ".alu_a"}, alu_a, r1);
      check({tag, ".exec_valid"}, 64'(out_valid), 64'd0);
      check({tag, ".exec_ready"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end else begin
      check({tag, ".alu_op_kept"}, 64'(alu_op), 64'(exp_alu_op));
    end
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, out_result, e.res);
    check({tag, ".taken"}, 64'(out_branch_taken), 64'(e.taken));
    check({tag, ".illegal"}, 64'(out_illegal), 64'(!e.legal));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_result"}, out_result, e.res);
      check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_count"}, 64'(op_count), 64'(exp_count));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check({tag, ".after_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".after_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".count"}, 64'(op_count), 64'(exp_count));
  endtask

  initial begin
    logic [6:0] opc_tab [7];
    logic [63:0] r1, r2;
    opc_tab[0] = 7'b0110011; opc_tab[1] = 7'b0010011; opc_tab[2] = 7'b0000011;
    opc_tab[3] = 7'b0100011; opc_tab[4] = 7'b1100011; opc_tab[5] = 7'b0001011;
    opc_tab[6] = 7'b1111111;
    exp_count = 16'd0;
    exp_alu_op = 4'b0000;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    scramble_inputs();

    // Reset held two cycles with in_valid asserted.
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.op_count", 64'(op_count), 64'd0);
    check("reset.alu_op", 64'(alu_op), 64'd0);
    check("reset.out_result", out_result, 64'd0);
    check("reset.illegal", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;

    // First accept right after release: R-type SUB 10-3.
    do_op("sub", 7'b0110011, 3'b000, 1'b1, 64'd10, 64'd3, 64'd0, 0, 1'b1);
    do_op("add_wrap", 7'b0110011, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1'b0);
    do_op("addi", 7'b0010011, 3'b000, 1'b0, 64'd4, 64'd99, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1'b0);
    do_op("beq_eq", 7'b1100011, 3'b000, 1'b0, 64'd5, 64'd5, 64'd0, 0, 1'b0);
    do_op("bne_eq", 7'b1100011, 3'b001, 1'b0, 64'd5, 64'd5, 64'd0, 0, 1'b0);
    do_op("bne_ne", 7'b1100011, 3'b001, 1'b0, 64'd5, 64'd6, 64'd0, 0, 1'b0);
    do_op("nor_bp", 7'b0001011, 3'b000, 1'b0, 64'd0, 64'd0, 64'd0, 5, 1'b0);
    do_op("illegal", 7'b1111111, 3'b000, 1'b0, 64'd1, 64'd2, 64'd3, 1, 1'b0);
    do_op("r_bad_f3", 7'b0110011, 3'b001, 1'b0, 64'd1, 64'd2, 64'd3, 0, 1'b0);

    // Reset while the ADD sits in EXEC discards it.
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7_b5 = 1'b0;
    rs1_val = 64'd1; rs2_val = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = 16'd0;
    exp_alu_op = 4'b0000;
    check("midreset.out_valid", 64'(out_valid), 64'd0);
    check("midreset.op_count", 64'(op_count), 64'd0);
    check("midreset.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("midreset.still_idle", 64'(out_valid), 64'd0);

    // Randomized instruction mix against the reference model.
    for (int n = 0; n < 60; n++) begin
      r1 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 8)) : {$urandom, $urandom};
      r2 = ($urandom_range(0, 1) == 0) ? r1 : {$urandom, $urandom};
      do_op("rand", opc_tab[$urandom_range(0, 6)], 3'($urandom), 1'($urandom),
            r1, r2, {$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
